bus_initiator: RTL

- Single-outstanding bus master for the AZPR-style peripheral bus (cs_/as_/rw/addr/wr_data/rd_data/rdy_).
- Converts a valid/ready command from a host into one bus access, waits for the active-low rdy_, and returns a valid/ready response.
- Used to drive GPIO-class slaves from a debug/loader path or a test harness.
- Aborts with an error flag if the slave does not respond within a bounded number of cycles.

---
 rtl/bus_initiator.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bus_initiator.sv
// Single-outstanding initiator for the AZPR peripheral bus: turns one host
// command into one cs_/as_ access, then holds the response until the host takes it.
module bus_initiator #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              cs_,
  output logic              as_,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
  // valid and its payload stay stable until that edge, ready may change freely.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Last count value of an access; reaching it with rdy_ still high aborts.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic                cs_q, cs_d;
  logic                as_q, as_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      cs_q        <= 1'b1;
      as_q        <= 1'b1;
      rw_q        <= 1'b1;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cs_q        <= cs_d;
      as_q        <= as_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    cs_d        = cs_q;
    as_d        = as_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rw_d      = req_rw;
          addr_d    = req_addr;
          wr_data_d = req_wdata;
          cs_d      = 1'b0;
          as_d      = 1'b0;
          count_d   = '0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A ready on the final count still completes normally.
        if (!rdy_) begin
          rsp_rdata_d = rw_q ? rd_data : '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b1;
          as_d        = 1'b1;
          state_d     = ST_RESP;
        end else if (count_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cs_d        = 1'b1;
          as_d        = 1'b1;
          state_d     = ST_RESP;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      ST_RESP: begin
        // rdy_ is not looked at here, so a slave's trailing ready is dropped.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs_       = cs_q;
  assign as_       = as_q;
  assign rw        = rw_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;

endmodule
